matrix_op_sequencer: RTL and testbench

- Command-driven initiator for the dual-read/single-write matrix store.
- Accepts one matrix instruction (op, dst, src1, src2, generated flag), drives the store's read indices, latches both operand matrices and computes the result row by row.
- Writes the full result matrix back in a single write cycle.
- Sits between the instruction decoder and the matrix store. It is the only driver of the store's read, write and write-enable inputs.

---
 rtl/matrix_op_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_op_sequencer
//
// Command-driven initiator for the dual-read/single-write matrix store.
// Takes one matrix instruction, points the store's read ports at the two
// operands, latches them, computes the result one row per cycle and writes
// the whole result matrix back in a single write cycle.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   instruction handshake (ready only while idle)
//   cmd_op                00 ADD, 01 SUB, 10 element MUL, 11 MATMUL
//   cmd_gen               src2 is a constant value rather than a store index
//   cmd_dst/src1/src2     destination, operand indices (src2 = constant if gen)
//   mem_read1/mem_read2   store read indices (store reads are combinational)
//   mem_generated_enable  store generated-operand select, high in LOAD only
//   mem_data1/mem_data2   operand matrices, packed [0:W-1][0:W-1][31:0]
//   mem_write, mem_write_enable, mem_write_data   result write port
//   busy                  high whenever not idle
//   done                  one-cycle pulse together with mem_write_enable
// -----------------------------------------------------------------------------
`ifndef WIDTH_BIT
`define WIDTH_BIT 2
`endif
`ifndef INDEX_BIT
`define INDEX_BIT 4
`endif

module matrix_op_sequencer #(
    parameter int WIDTH = 2**`WIDTH_BIT,
    parameter int IDX   = `INDEX_BIT
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [1:0]                          cmd_op,
    input  logic                                cmd_gen,
    input  logic [IDX-1:0]                      cmd_dst,
    input  logic [IDX-1:0]                      cmd_src1,
    input  logic [IDX-1:0]                      cmd_src2,
    output logic [IDX-1:0]                      mem_read1,
    output logic [IDX-1:0]                      mem_read2,
    output logic                                mem_generated_enable,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]   mem_data1,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]   mem_data2,
    output logic [IDX-1:0]                      mem_write,
    output logic                                mem_write_enable,
    output logic [0:WIDTH-1][0:WIDTH-1][31:0]   mem_write_data,
    output logic                                busy,
    output logic                                done
);

    localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef logic [0:WIDTH-1][0:WIDTH-1][31:0] mat_t;
    typedef logic [0:WIDTH-1][31:0]            row_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t         state_reg;
    logic [1:0]     op_reg;
    logic           gen_reg;
    logic [IDX-1:0] dst_reg;
    logic [IDX-1:0] src2_reg;
    mat_t           a_reg;
    mat_t           b_reg;
    mat_t           r_reg;
    logic [RW-1:0]  row_reg;

    row_t           row_next;
    mat_t           gen_mat;

    // Constant operand: every element is the zero-extended src2 field.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                gen_mat[i][j] = 32'(src2_reg);
            end
        end
    end

    // One result row per cycle; each column has its own datapath. The MATMUL
    // dot product is a chain of partial sums kept at 32 bits, so overflow
    // wraps exactly as a 32-bit accumulator would.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_col
            logic [0:WIDTH][31:0] psum;
            logic [31:0]          elem;

            assign psum[0] = '0;
            for (genvar gk = 0; gk < WIDTH; gk++) begin : g_dot
                assign psum[gk+1] = psum[gk] + a_reg[row_reg][gk] * b_reg[gk][gi];
            end

            always_comb begin
                elem = '0;
                case (op_reg)
                    OP_ADD:  elem = a_reg[row_reg][gi] + b_reg[row_reg][gi];
                    OP_SUB:  elem = a_reg[row_reg][gi] - b_reg[row_reg][gi];
                    OP_MUL:  elem = a_reg[row_reg][gi] * b_reg[row_reg][gi];
                    default: elem = psum[WIDTH];
                endcase
            end

            assign row_next[gi] = elem;
        end
    endgenerate

    assign mem_write_data = r_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg            <= S_IDLE;
            cmd_ready            <= 1'b1;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            mem_write_enable     <= 1'b0;
            mem_generated_enable <= 1'b0;
            mem_read1            <= '0;
            mem_read2            <= '0;
            mem_write            <= '0;
            op_reg               <= '0;
            gen_reg              <= 1'b0;
            dst_reg              <= '0;
            src2_reg             <= '0;
            a_reg                <= '0;
            b_reg                <= '0;
            r_reg                <= '0;
            row_reg              <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_reg               <= cmd_op;
                        gen_reg              <= cmd_gen;
                        dst_reg              <= cmd_dst;
                        src2_reg             <= cmd_src2;
                        mem_read1            <= cmd_src1;
                        mem_read2            <= cmd_src2;
                        // Registered here so it is high for the LOAD cycle.
                        mem_generated_enable <= cmd_gen;
                        cmd_ready            <= 1'b0;
                        busy                 <= 1'b1;
                        state_reg            <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Operands are captured here, so a destination that
                    // aliases a source cannot disturb the computation.
                    a_reg                <= mem_data1;
                    b_reg                <= gen_reg ? gen_mat : mem_data2;
                    row_reg              <= '0;
                    mem_generated_enable <= 1'b0;
                    state_reg            <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    r_reg[row_reg] <= row_next;
                    row_reg        <= row_reg + RW'(1);
                    if (row_reg == RW'(WIDTH - 1)) begin
                        mem_write        <= dst_reg;
                        mem_write_enable <= 1'b1;
                        done             <= 1'b1;
                        state_reg        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_write_enable <= 1'b0;
                    done             <= 1'b0;
                    busy             <= 1'b0;
                    cmd_ready        <= 1'b1;
                    state_reg        <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_op_sequencer
//
// Drives matrix_op_sequencer against a behavioural matrix store. A reference
// model computes each result from the instruction and the store contents, and
// a per-cycle checker compares handshake, timing and write data against it.
// Directed cases pin the model with hand-computed values; randomized
// instructions (including mid-operation resets) follow.
// -----------------------------------------------------------------------------
module tb_matrix_op_sequencer;

    localparam int W   = 4;
    localparam int IDX = 4;
    localparam int MW  = W * W * 32;

    typedef logic [0:W-1][0:W-1][31:0] mat_t;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = '0;
    logic           cmd_gen = 1'b0;
    logic [IDX-1:0] cmd_dst = '0;
    logic [IDX-1:0] cmd_src1 = '0;
    logic [IDX-1:0] cmd_src2 = '0;
    logic [IDX-1:0] mem_read1;
    logic [IDX-1:0] mem_read2;
    logic           mem_generated_enable;
    mat_t           mem_data1;
    mat_t           mem_data2;
    logic [IDX-1:0] mem_write;
    logic           mem_write_enable;
    mat_t           mem_write_data;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    matrix_op_sequencer #(.WIDTH(W), .IDX(IDX)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_gen              (cmd_gen),
        .cmd_dst              (cmd_dst),
        .cmd_src1             (cmd_src1),
        .cmd_src2             (cmd_src2),
        .mem_read1            (mem_read1),
        .mem_read2            (mem_read2),
        .mem_generated_enable (mem_generated_enable),
        .mem_data1            (mem_data1),
        .mem_data2            (mem_data2),
        .mem_write            (mem_write),
        .mem_write_enable     (mem_write_enable),
        .mem_write_data       (mem_write_data),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic mat_t fill(input logic [31:0] v);
        mat_t m;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                m[i][j] = v;
        return m;
    endfunction

    // Reference arithmetic: full-width products and sums, truncated at the end.
    function automatic mat_t model(input logic [1:0] op, input mat_t a, input mat_t b);
        mat_t r;
        logic [63:0] acc;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                case (op)
                    2'b00: r[i][j] = a[i][j] + b[i][j];
                    2'b01: r[i][j] = a[i][j] - b[i][j];
                    2'b10: begin
                        acc = {32'd0, a[i][j]} * {32'd0, b[i][j]};
                        r[i][j] = acc[31:0];
                    end
                    default: begin
                        acc = '0;
                        for (int k = 0; k < W; k++)
                            acc = acc + {32'd0, a[i][k]} * {32'd0, b[k][j]};
                        r[i][j] = acc[31:0];
                    end
                endcase
            end
        end
        return r;
    endfunction

    // ---------------- behavioural matrix store ----------------
    mat_t           store [16];
    int             wr_count = 0;
    logic           pre_en = 1'b0;
    logic [IDX-1:0] pre_idx = '0;
    mat_t           pre_data = '0;

    always @(posedge CLK) begin
        if (pre_en) begin
            store[pre_idx] <= pre_data;
        end else if (!RST && mem_write_enable) begin
            store[mem_write] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    always_comb begin
        mem_data1 = store[mem_read1];
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                mem_data2[i][j] = mem_generated_enable ? 32'(mem_read2) : store[mem_read2][i][j];
    end

    // ---------------- per-cycle checker ----------------
    int             cyc = 0;
    int             phase = -1;
    int             acc_last = 0;
    int             we_lat = 0;
    int             gen_hi = 0;
    int             acc_log [$];
    logic [1:0]     e_op;
    logic           e_gen;
    logic [IDX-1:0] e_dst, e_s1, e_s2;
    mat_t           e_res;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) begin
            phase = -1;
            chk("rst_ready", cmd_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_we", mem_write_enable, 0);
            chk("rst_done", done, 0);
            chk("rst_gen", mem_generated_enable, 0);
        end else begin
            if (mem_generated_enable) gen_hi++;
            if (phase >= 0) phase++;
            if (phase < 0) begin
                chk("idle_ready", cmd_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_we", mem_write_enable, 0);
                chk("idle_done", done, 0);
                chk("idle_gen", mem_generated_enable, 0);
                if (cmd_valid) begin
                    phase    = 0;
                    acc_last = cyc;
                    acc_log.push_back(cyc);
                    e_op  = cmd_op;
                    e_gen = cmd_gen;
                    e_dst = cmd_dst;
                    e_s1  = cmd_src1;
                    e_s2  = cmd_src2;
                    e_res = model(cmd_op, store[cmd_src1],
                                  cmd_gen ? fill(32'(cmd_src2)) : store[cmd_src2]);
                end
            end else begin
                chk("busy_ready", cmd_ready, 0);
                chk("busy_busy", busy, 1);
                if (phase == 1) begin
                    chk("load_gen", mem_generated_enable, e_gen);
                    chk("load_read1", mem_read1, e_s1);
                    chk("load_read2", mem_read2, e_s2);
                    chk("load_we", mem_write_enable, 0);
                end else if (phase <= W + 1) begin
                    chk("comp_gen", mem_generated_enable, 0);
                    chk("comp_we", mem_write_enable, 0);
                    chk("comp_done", done, 0);
                end else begin
                    we_lat = cyc - acc_last;
                    chk("wr_we", mem_write_enable, 1);
                    chk("wr_done", done, 1);
                    chk("wr_gen", mem_generated_enable, 0);
                    chk("wr_idx", mem_write, e_dst);
                    chk("wr_data", mem_write_data, e_res);
                    $display("op=%0d gen=%0d dst=%0d src1=%0d src2=%0d written", e_op, e_gen, e_dst, e_s1, e_s2);
                    phase = -1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic preload(input int idx, input mat_t m);
        @(posedge CLK); #1;
        pre_en   = 1'b1;
        pre_idx  = idx[IDX-1:0];
        pre_data = m;
        @(posedge CLK); #1;
        pre_en   = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic g, input logic [IDX-1:0] d,
                         input logic [IDX-1:0] s1, input logic [IDX-1:0] s2, input bit abort);
        int wc;
        bit ok;
        @(posedge CLK); #1;
        cmd_op = op; cmd_gen = g; cmd_dst = d; cmd_src1 = s1; cmd_src2 = s2;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        wc = wr_count;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        if (abort) begin
            repeat ($urandom_range(1, W)) @(posedge CLK);
            #2 RST = 1'b1;
            #1;
            chk("abort_we_async", mem_write_enable, 0);
            chk("abort_ready_async", cmd_ready, 1);
            @(posedge CLK); #1;
            RST = 1'b0;
            @(negedge CLK);
            chk("abort_ready_after", cmd_ready, 1);
            chk("abort_busy_after", busy, 0);
            repeat (W + 4) @(posedge CLK);
            #1;
            chk("abort_nowrite", wr_count, wc);
            $display("abort op=%0d dst=%0d: no write", op, d);
        end else begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge CLK); #1;
                if (wr_count != wc) begin ok = 1'b1; break; end
            end
            if (!ok) chk("done_timeout", 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        mat_t m;
        int   wc;
        bit   ok;

        // Fill the whole store while held in reset.
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < W; i++)
                for (int j = 0; j < W; j++)
                    m[i][j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100));
            preload(n, m);
        end
        @(negedge CLK);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle10_ready", cmd_ready, 1);
            chk("idle10_busy", busy, 0);
            chk("idle10_we", mem_write_enable, 0);
        end

        // ADD 5 + 7
        preload(1, fill(32'd5));
        preload(2, fill(32'd7));
        do_op(2'b00, 1'b0, 4'd3, 4'd1, 4'd2, 1'b0);
        chk("add_latency", we_lat, 6);
        chk("add_result", store[3], fill(32'd12));

        // SUB wraps
        preload(1, fill(32'd0));
        preload(2, fill(32'd1));
        do_op(2'b01, 1'b0, 4'd4, 4'd1, 4'd2, 1'b0);
        chk("sub_wrap", store[4], fill(32'hFFFF_FFFF));

        // Generated MATMUL: identity x const 3, written over its own source
        m = '0;
        for (int i = 0; i < W; i++) m[i][i] = 32'd1;
        preload(1, m);
        gen_hi = 0;
        do_op(2'b11, 1'b1, 4'd1, 4'd1, 4'd3, 1'b0);
        chk("gen_matmul", store[1], fill(32'd3));
        chk("gen_enable_cycles", gen_hi, 1);

        // A[i][j] = i + j
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                m[i][j] = 32'(i + j);
        preload(5, m);
        do_op(2'b11, 1'b0, 4'd6, 4'd5, 4'd5, 1'b0);
        chk("matmul_00", store[6][0][0], 32'd14);
        chk("matmul_33", store[6][3][3], 32'd86);
        do_op(2'b10, 1'b0, 4'd7, 4'd5, 4'd5, 1'b0);
        chk("mul_33", store[7][3][3], 32'd36);
        chk("mul_12", store[7][1][2], 32'd9);
        preload(8, fill(32'h0001_0000));
        do_op(2'b10, 1'b0, 4'd9, 4'd8, 4'd8, 1'b0);
        chk("mul_overflow", store[9], fill(32'd0));

        // Back-to-back: valid held across a busy operation
        acc_log.delete();
        wc = wr_count;
        @(posedge CLK); #1;
        cmd_op = 2'b00; cmd_gen = 1'b0; cmd_dst = 4'd10; cmd_src1 = 4'd5; cmd_src2 = 4'd5;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK); #1;
            if (acc_log.size() >= 2) begin ok = 1'b1; break; end
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        if (!ok) chk("b2b_timeout", 0, 1);
        else     chk("b2b_gap", acc_log[1] - acc_log[0], W + 3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (wr_count >= wc + 2) begin ok = 1'b1; break; end
        end
        if (!ok) chk("b2b_done_timeout", 0, 1);

        // Reset during COMPUTE
        do_op(2'b00, 1'b0, 4'd11, 4'd1, 4'd2, 1'b1);

        // Randomized instructions
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            do_op(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
